// File: rtl/hazard_stall_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_if
//
// Purpose : bundles the hazard-detection inputs and front-end control outputs
//           exchanged between the MIPS pipeline datapath and the stall/flush
//           sequencer.
//
// Signals :
//   ext_freeze       external hold of the whole front end
//   id_rs/id_rt      source registers of the instruction in ID
//   id_use_rs/rt     ID instruction actually reads rs / rt
//   id_is_branch     ID instruction is beq/bne (compared in ID)
//   id_branch_taken  ID branch comparator result
//   id_is_jump       ID instruction is j/jal/jr
//   id_ex_*          load/write/destination info of the ID/EX register
//   ex_mem_*         load/destination info of the EX/MEM register
//   pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active
//                    control outputs of the sequencer
//
// Modports: master = pipeline datapath side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface hazard_stall_controller_if #(
  parameter int REG_W = 5
);
  logic             ext_freeze;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             id_is_jump;
  logic             id_ex_mem_read;
  logic             id_ex_reg_write;
  logic [REG_W-1:0] id_ex_dst;
  logic             ex_mem_mem_read;
  logic [REG_W-1:0] ex_mem_dst;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             stall_active;

  modport master (
    output ext_freeze, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_branch_taken, id_is_jump, id_ex_mem_read, id_ex_reg_write,
           id_ex_dst, ex_mem_mem_read, ex_mem_dst,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active
  );

  modport slave (
    input  ext_freeze, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_branch_taken, id_is_jump, id_ex_mem_read, id_ex_reg_write,
           id_ex_dst, ex_mem_mem_read, ex_mem_dst,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Purpose : stall/flush sequencer for the 5-stage MIPS core. Resolves the
//           hazards EX forwarding cannot: load-use, branch operands needed in
//           ID (from an ALU op in EX, a load in EX or a load in MEM), taken
//           branch/jump flush and external freeze.
//
// Ports   :
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (outputs forced while low)
//   bus     hazard_stall_controller_if.slave (hazard inputs, control outputs)
//   stall_cycles, flush_count (only with HAZARD_STATS_EN) saturating counters
//
// Optional feature: define HAZARD_STATS_EN to add the statistics counters.
//
// The stall is asserted combinationally on the detect cycle. Only a branch
// waiting on a load in EX needs a second stall cycle, sequenced by STALL1.
// STALL2 is encoded for a longer memory latency but behaves as STALL1.
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef HAZARD_STATS_EN
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] flush_count,
`endif
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL2 = 2'd1,
    STALL1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [REG_W-1:0] id_rs, id_rt, id_ex_dst, ex_mem_dst;
  logic             match_ex, match_mem;
  logic             haz_lu, haz_ba, haz_bl2, haz_bl1, haz_any;
  logic             redirect;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush;

  assign id_rs      = bus.id_rs;
  assign id_rt      = bus.id_rt;
  assign id_ex_dst  = bus.id_ex_dst;
  assign ex_mem_dst = bus.ex_mem_dst;

  // Register 0 never carries a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] x,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic use_rs,
                                     input logic use_rt);
    return (x != '0) && (((x == rs) && use_rs) || ((x == rt) && use_rt));
  endfunction

  assign match_ex  = reg_match(id_ex_dst, id_rs, id_rt, bus.id_use_rs, bus.id_use_rt);
  assign match_mem = reg_match(ex_mem_dst, id_rs, id_rt, bus.id_use_rs, bus.id_use_rt);

  assign haz_lu  = bus.id_ex_mem_read && match_ex;
  assign haz_ba  = bus.id_is_branch && bus.id_ex_reg_write && !bus.id_ex_mem_read && match_ex;
  assign haz_bl2 = bus.id_is_branch && bus.id_ex_mem_read && match_ex;
  assign haz_bl1 = bus.id_is_branch && bus.ex_mem_mem_read && match_mem;
  assign haz_any = haz_lu || haz_ba || haz_bl2 || haz_bl1;

  assign redirect = bus.id_is_jump || (bus.id_is_branch && bus.id_branch_taken);

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
    end else if (bus.ext_freeze) begin
      // Freeze dominates everything: no bubble, no flush, state held.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (haz_any) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            // Detect cycle is the first stall cycle; only BL2 needs another.
            if (haz_bl2) state_d = STALL1;
          end else if (redirect) begin
            if_id_flush = 1'b1;
          end
        end
        STALL2, STALL1: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.stall_active = rst_n && (state_q != RUN);

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [STALL_CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!if_id_write && !bus.ext_freeze && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (if_id_flush && (flush_count_q != '1))
      flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // Counter width only matters when the statistics are built in.
  logic unused_cfg;
  assign unused_cfg = |STALL_CNT_W;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  localparam int REG_W = 5;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.REG_W(REG_W)) hz ();

`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  hazard_stall_controller #(.REG_W(REG_W), .STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef HAZARD_STATS_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .bus          (hz)
  );

  // expected/actual packed as {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active}
  typedef struct {
    string      name;
    logic       frz;
    logic [4:0] rs, rt;
    logic       urs, urt, br, tk, jmp, exmr, exrw;
    logic [4:0] exdst;
    logic       memmr;
    logic [4:0] memdst;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] SEQ   = 5'b00101;
  localparam logic [4:0] FLUSH = 5'b11010;
  localparam logic [4:0] FROZE = 5'b00000;
  localparam logic [4:0] FRZST = 5'b00001;

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(string n, logic frz, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic br, logic tk, logic jmp,
                              logic exmr, logic exrw, logic [4:0] exdst,
                              logic memmr, logic [4:0] memdst, logic [4:0] exp);
    vec_t v;
    v.name = n; v.frz = frz; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.br = br; v.tk = tk; v.jmp = jmp; v.exmr = exmr; v.exrw = exrw;
    v.exdst = exdst; v.memmr = memmr; v.memdst = memdst; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.ext_freeze      = v.frz;
    hz.id_rs           = v.rs;
    hz.id_rt           = v.rt;
    hz.id_use_rs       = v.urs;
    hz.id_use_rt       = v.urt;
    hz.id_is_branch    = v.br;
    hz.id_branch_taken = v.tk;
    hz.id_is_jump      = v.jmp;
    hz.id_ex_mem_read  = v.exmr;
    hz.id_ex_reg_write = v.exrw;
    hz.id_ex_dst       = v.exdst;
    hz.ex_mem_mem_read = v.memmr;
    hz.ex_mem_dst      = v.memdst;
  endtask

  task automatic check(input string n, input logic [4:0] exp);
    logic [4:0] got;
    got = {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.if_id_flush, hz.stall_active};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc/ifid/bub/flush/sa=%b expected %b", n, got, exp);
    end else begin
      $display("ok   %s: pc/ifid/bub/flush/sa=%b", n, got);
    end
  endtask

  vec_t tbl[$];
  vec_t idle, bl2v;

  initial begin
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    bl2v = mk("bl2", 0, 3, 0, 1, 0, 1, 0, 0, 1, 1, 3, 0, 0, STALL);

    //            name              frz rs rt urs urt br tk jmp exmr exrw exd mmr md  exp
    tbl.push_back(mk("idle0",        0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    tbl.push_back(mk("lu_rs",        0, 2, 1, 1, 1, 0, 0, 0, 1, 1, 2, 0, 0, STALL));
    tbl.push_back(mk("after_lu",     0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    tbl.push_back(mk("bl2_detect",   0, 3, 0, 1, 0, 1, 0, 0, 1, 1, 3, 0, 0, STALL));
    tbl.push_back(mk("bl2_stall1",   0, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 3, SEQ));
    tbl.push_back(mk("br_taken",     0, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, FLUSH));
    tbl.push_back(mk("ba_rt",        0, 0, 4, 0, 1, 1, 1, 0, 0, 1, 4, 0, 0, STALL));
    tbl.push_back(mk("ba_dst0",      0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, NORM));
    tbl.push_back(mk("ba_no_use_rt", 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 4, 0, 0, NORM));
    tbl.push_back(mk("jump",         0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FLUSH));
    tbl.push_back(mk("bl1_taken",    0, 5, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 5, STALL));
    tbl.push_back(mk("after_bl1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    tbl.push_back(mk("lu_rt_jump",   0, 0, 7, 0, 1, 0, 0, 1, 1, 1, 7, 0, 0, STALL));
    tbl.push_back(mk("alu_fwd_ok",   0, 6, 0, 1, 0, 0, 0, 0, 0, 1, 6, 0, 0, NORM));
    tbl.push_back(mk("freeze_run",   1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, FROZE));
    tbl.push_back(mk("mem_ld_nobr",  0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, NORM));

    // Reset: outputs forced even with a hazard on the inputs.
    apply(tbl[1]);
    @(negedge clk); #1;
    check("reset_forced", 5'b00100);
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
`endif
    apply(idle);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle", NORM);

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check(tbl[i].name, tbl[i].exp);
    end

    // Freeze held for 3 cycles inside STALL1, then the remaining stall cycle.
    @(negedge clk); apply(bl2v); #1; check("frz_bl2_detect", STALL);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); apply(idle); hz.ext_freeze = 1'b1; #1;
      check($sformatf("frz_hold%0d", k), FRZST);
    end
    @(negedge clk); apply(idle); #1; check("frz_release_stall", SEQ);
    @(negedge clk); apply(idle); #1; check("frz_back_run", NORM);

    // Asynchronous reset in the middle of a stall.
    @(negedge clk); apply(bl2v); #1; check("rst_bl2_detect", STALL);
    @(negedge clk); apply(idle); #1; check("rst_in_stall1", SEQ);
    #2 rst_n = 1'b0;
    #1 check("rst_async_forced", 5'b00100);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_released_run", NORM);
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      errors++;
      $display("FAIL stats_after_rst: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
`endif
    @(negedge clk); apply(idle); #1; check("final_idle", NORM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
